// File: rtl/pll_reset_sequencer_pkg.sv
// Shared encodings and sizing helpers for the PLL reset sequencer.
// The FSM encoding doubles as the debug seq_state value.
package pll_reset_sequencer_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        CORE_UP   = 2'd2,
        RUN       = 2'd3
    } seq_state_e;

    function automatic int cnt_width(input int a, input int b);
        int m;
        int w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Lock input and staged-reset/status bundle of the sequencer.
// master = sequencer side, slave = consumer of the resets.
interface pll_reset_sequencer_if #(
    parameter int LOSS_CNT_W = 4
);
    logic                  pll_lock;
    logic                  core_rst_n;
    logic                  periph_rst_n;
    logic                  sys_ready;
    logic [LOSS_CNT_W-1:0] lock_loss_cnt;
    logic [1:0]            seq_state;

    modport master (
        input  pll_lock,
        output core_rst_n,
        output periph_rst_n,
        output sys_ready,
        output lock_loss_cnt,
        output seq_state
    );

    modport slave (
        output pll_lock,
        input  core_rst_n,
        input  periph_rst_n,
        input  sys_ready,
        input  lock_loss_cnt,
        input  seq_state
    );
endinterface

// File: rtl/pll_reset_sequencer_sync_ff_chain.sv
// Multi-flop synchroniser for a single asynchronous input.
// Clears to 0 on reset so a held-high input is not trusted until re-sampled.
module sync_ff_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];
endmodule

// File: rtl/pll_reset_sequencer.sv
// Staged reset release for core then peripherals, gated on a stable PLL lock.
// Lock loss drops every reset at once and bumps a saturating loss counter.
module pll_reset_sequencer
    import pll_reset_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES           = 2,
    parameter int LOCK_STABLE_CYCLES    = 1024,
    parameter int CORE_TO_PERIPH_CYCLES = 16,
    parameter int LOSS_CNT_W            = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pll_reset_sequencer_if.master bus
);
    localparam int CNT_W =
        cnt_width(LOCK_STABLE_CYCLES, CORE_TO_PERIPH_CYCLES);
    localparam logic [CNT_W-1:0] STAB_LOAD =
        CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C2P_LOAD =
        CNT_W'(CORE_TO_PERIPH_CYCLES - 1);

    logic lock_s;

    seq_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  core_q, core_d;
    logic                  periph_q, periph_d;
    logic                  ready_q, ready_d;
    logic [LOSS_CNT_W-1:0] loss_q, loss_d;
    logic [LOSS_CNT_W-1:0] loss_inc;

    sync_ff_chain #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.pll_lock),
        .q     (lock_s)
    );

    assign loss_inc = (loss_q == '1) ? loss_q : loss_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= WAIT_LOCK;
            cnt_q    <= '0;
            core_q   <= 1'b0;
            periph_q <= 1'b0;
            ready_q  <= 1'b0;
            loss_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            core_q   <= core_d;
            periph_q <= periph_d;
            ready_q  <= ready_d;
            loss_q   <= loss_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        core_d   = core_q;
        periph_d = periph_q;
        ready_d  = ready_q;
        loss_d   = loss_q;
        unique case (state_q)
            WAIT_LOCK: begin
                core_d   = 1'b0;
                periph_d = 1'b0;
                ready_d  = 1'b0;
                if (lock_s) begin
                    state_d = STABILIZE;
                    cnt_d   = STAB_LOAD;
                end
            end
            STABILIZE: begin
                // A glitch here is not a real loss: restart, don't count.
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == '0) begin
                    state_d = CORE_UP;
                    core_d  = 1'b1;
                    cnt_d   = C2P_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CORE_UP: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    core_d  = 1'b0;
                    loss_d  = loss_inc;
                end else if (cnt_q == '0) begin
                    state_d  = RUN;
                    periph_d = 1'b1;
                    ready_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d  = WAIT_LOCK;
                    core_d   = 1'b0;
                    periph_d = 1'b0;
                    ready_d  = 1'b0;
                    loss_d   = loss_inc;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase
    end

    assign bus.core_rst_n    = core_q;
    assign bus.periph_rst_n  = periph_q;
    assign bus.sys_ready     = ready_q;
    assign bus.lock_loss_cnt = loss_q;
    assign bus.seq_state     = state_q;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed and table-driven checks of the PLL reset sequencer.
// Small parameters keep every release window short.
module tb_pll_reset_sequencer;
    import pll_reset_sequencer_pkg::*;

    localparam int SS  = 2;
    localparam int LSC = 8;
    localparam int C2P = 4;
    localparam int LW  = 4;

    typedef struct {
        logic       lock;
        logic       core;
        logic       periph;
        logic       ready;
        logic [1:0] state;
        logic [3:0] loss;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    vec_t vecs [38];

    pll_reset_sequencer_if #(.LOSS_CNT_W(LW)) bus ();

    pll_reset_sequencer #(
        .SYNC_STAGES           (SS),
        .LOCK_STABLE_CYCLES    (LSC),
        .CORE_TO_PERIPH_CYCLES (C2P),
        .LOSS_CNT_W            (LW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d @%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("periph_implies_core",
            int'(bus.periph_rst_n & ~bus.core_rst_n), 0);
        chk("ready_eq_run", int'(bus.sys_ready),
            int'(bus.seq_state == 2'(RUN)));
    endtask

    task automatic set_rows(input int lo, input int hi, input logic lk,
                            input logic c, input logic p, input logic r,
                            input seq_state_e s, input logic [3:0] l);
        for (int i = lo; i <= hi; i++) begin
            vecs[i] = '{lk, c, p, r, 2'(s), l};
        end
    endtask

    task automatic chk_all(input string tag, input int c, input int p,
                           input int r, input int s, input int l);
        chk({tag, " core"}, int'(bus.core_rst_n), c);
        chk({tag, " periph"}, int'(bus.periph_rst_n), p);
        chk({tag, " ready"}, int'(bus.sys_ready), r);
        chk({tag, " state"}, int'(bus.seq_state), s);
        chk({tag, " loss"}, int'(bus.lock_loss_cnt), l);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_loss;
        int n;

        // Per-edge vectors, edge 0 is the first edge after reset release.
        set_rows(0, 1, 1'b1, 1'b0, 1'b0, 1'b0, WAIT_LOCK, 4'd0);
        set_rows(2, 9, 1'b1, 1'b0, 1'b0, 1'b0, STABILIZE, 4'd0);
        set_rows(10, 13, 1'b1, 1'b1, 1'b0, 1'b0, CORE_UP, 4'd0);
        set_rows(14, 17, 1'b1, 1'b1, 1'b1, 1'b1, RUN, 4'd0);
        set_rows(18, 19, 1'b0, 1'b1, 1'b1, 1'b1, RUN, 4'd0);
        set_rows(20, 20, 1'b0, 1'b0, 1'b0, 1'b0, WAIT_LOCK, 4'd1);
        set_rows(21, 22, 1'b1, 1'b0, 1'b0, 1'b0, WAIT_LOCK, 4'd1);
        set_rows(23, 30, 1'b1, 1'b0, 1'b0, 1'b0, STABILIZE, 4'd1);
        set_rows(31, 34, 1'b1, 1'b1, 1'b0, 1'b0, CORE_UP, 4'd1);
        set_rows(35, 37, 1'b1, 1'b1, 1'b1, 1'b1, RUN, 4'd1);

        bus.pll_lock = 1'b0;
        repeat (3) tick();
        chk_all("reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 38; i++) begin
            bus.pll_lock = vecs[i].lock;
            tick();
            chk_all($sformatf("vec%0d", i), int'(vecs[i].core),
                    int'(vecs[i].periph), int'(vecs[i].ready),
                    int'(vecs[i].state), int'(vecs[i].loss));
        end

        // Second loss from RUN, then a one-cycle glitch mid-stabilise.
        bus.pll_lock = 1'b0;
        repeat (3) tick();
        chk_all("loss2", 0, 0, 0, 0, 2);
        bus.pll_lock = 1'b1;
        repeat (6) tick();
        bus.pll_lock = 1'b0;
        tick();
        bus.pll_lock = 1'b1;
        tick();
        chk("glitch e7 state", int'(bus.seq_state), int'(STABILIZE));
        tick();
        chk_all("glitch e8", 0, 0, 0, int'(WAIT_LOCK), 2);
        repeat (8) tick();
        chk_all("glitch e16", 0, 0, 0, int'(STABILIZE), 2);
        tick();
        chk_all("glitch e17", 1, 0, 0, int'(CORE_UP), 2);

        // Asynchronous reset in the middle of a CORE_UP cycle.
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0);
        repeat (2) tick();
        rst_n = 1'b1;

        // Saturation of the loss counter over 20 losses from RUN.
        exp_loss = 0;
        bus.pll_lock = 1'b1;
        for (int k = 0; k < 20; k++) begin
            n = 0;
            while (!bus.sys_ready && n < 60) begin
                tick();
                n++;
            end
            chk($sformatf("reach_run%0d", k), int'(bus.sys_ready), 1);
            bus.pll_lock = 1'b0;
            repeat (3) tick();
            exp_loss = (exp_loss == 15) ? 15 : exp_loss + 1;
            chk($sformatf("loss_sat%0d", k),
                int'(bus.lock_loss_cnt), exp_loss);
            bus.pll_lock = 1'b1;
        end

        // Random lock toggling; invariants are checked inside tick().
        for (int j = 0; j < 10000; j++) begin
            if ($urandom_range(0, 39) == 0) begin
                bus.pll_lock = ~bus.pll_lock;
            end
            tick();
        end
        chk("final_loss_sat", int'(bus.lock_loss_cnt), 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
